// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - controller-to-serializer signal bundle for the UART TX data path
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);

  // Word intake from the upstream producer
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_TYP;

  // Phase information from the TX controller FSM
  logic                  ser_en;
  logic [1:0]            mux_sel;

  // Serializer results back to the controller
  logic                  ser_data;
  logic                  ser_done;
  logic                  par_bit;
  logic                  pending;
  logic                  overrun;

  // Controller / producer side
  modport master (
    output P_DATA, DATA_VALID, PAR_TYP, ser_en, mux_sel,
    input  ser_data, ser_done, par_bit, pending, overrun
  );

  // Serializer side
  modport slave (
    input  P_DATA, DATA_VALID, PAR_TYP, ser_en, mux_sel,
    output ser_data, ser_done, par_bit, pending, overrun
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART TX shift register, parity and 1-deep word holding buffer
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [1:0]       MUX_DATA = 2'b10;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  hold_valid;
  logic                  par_q;
  logic                  overrun_q;
  logic                  data_phase;
  logic                  last_bit;

  // The controller only advances the shifter while it is in the data phase of a frame
  assign data_phase = bus.ser_en && (bus.mux_sel == MUX_DATA);
  assign last_bit   = (bit_cnt == LAST_BIT);

  assign bus.ser_data = shift_reg[0];
  assign bus.ser_done = data_phase && last_bit;
  assign bus.par_bit  = par_q;
  assign bus.pending  = hold_valid;
  assign bus.overrun  = overrun_q;

  // Shift path: load a word while idle (held word has priority), shift LSB-first in the data phase
  always_ff @(posedge CLK) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_q     <= 1'b0;
    end else if (!bus.ser_en) begin
      if (hold_valid) begin
        shift_reg <= hold_reg;
        bit_cnt   <= '0;
        par_q     <= (^hold_reg) ^ bus.PAR_TYP;
      end else if (bus.DATA_VALID) begin
        shift_reg <= bus.P_DATA;
        bit_cnt   <= '0;
        par_q     <= (^bus.P_DATA) ^ bus.PAR_TYP;
      end
    end else if (data_phase) begin
      // The last data bit stays in place; the counter rewinds for the next frame
      if (last_bit) begin
        bit_cnt <= '0;
      end else begin
        shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Holding buffer: absorbs one word per frame, drains into the shifter on an idle cycle
  always_ff @(posedge CLK) begin
    if (rst) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (!bus.ser_en) begin
        // The held word moves to the shifter this cycle; a coincident arrival refills the slot
        if (hold_valid) begin
          if (bus.DATA_VALID) begin
            hold_reg <= bus.P_DATA;
          end else begin
            hold_valid <= 1'b0;
          end
        end
      end else if (bus.DATA_VALID) begin
        if (hold_valid) begin
          overrun_q <= 1'b1;
        end else begin
          hold_reg   <= bus.P_DATA;
          hold_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic CLK = 1'b0;
  logic rst;

  always #5 CLK = ~CLK;

  uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic tb_held = 1'b0;

  // Expected data bits {ser_data, ser_done}, parity bits, and overrun cycle numbers
  logic [1:0] bit_q[$];
  logic       par_q[$];
  int         ovr_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops and compares whenever the DUT presents a data bit, parity phase or overrun
  always @(negedge CLK) begin
    logic [1:0] e;
    logic       p;
    int         oc;
    if (bus.ser_en && bus.mux_sel == 2'b10) begin
      if (bit_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data bit: got unexpected bit %0b at cycle %0d", bus.ser_data, cyc);
      end else begin
        e = bit_q.pop_front();
        check("ser_data", bus.ser_data, e[1]);
        check("ser_done", bus.ser_done, e[0]);
      end
    end else if (bus.ser_done) begin
      checks++; errors++;
      $display("FAIL ser_done outside data phase: got 1 expected 0 at cycle %0d", cyc);
    end
    if (bus.ser_en && bus.mux_sel == 2'b11) begin
      if (par_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL parity phase: got unexpected parity phase at cycle %0d", cyc);
      end else begin
        p = par_q.pop_front();
        check("par_bit", bus.par_bit, p);
      end
    end
    if (bus.overrun) begin
      if (ovr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL overrun: got unexpected pulse at cycle %0d expected none", cyc);
      end else begin
        oc = ovr_q.pop_front();
        check("overrun cycle", cyc, oc);
      end
    end
  end

  task automatic load(input logic [7:0] w, input logic exp_par);
    bus.ser_en = 1'b0; bus.mux_sel = 2'b00;
    bus.DATA_VALID = 1'b1; bus.P_DATA = w;
    step();
    bus.DATA_VALID = 1'b0;
    check("load ser_data", bus.ser_data, w[0]);
    check("load par_bit", bus.par_bit, exp_par);
    check("load pending", bus.pending, 1'b0);
  endtask

  task automatic idle_cycle(input logic dv, input logic [7:0] w, input logic [1:0] mux);
    bus.ser_en = 1'b0; bus.mux_sel = mux;
    bus.DATA_VALID = dv; bus.P_DATA = w;
    tb_held = tb_held & dv;
    step();
    bus.DATA_VALID = 1'b0;
  endtask

  // Drives START, SENDINGx8, PARITY, STOP; injects words on SENDING 2/4/6; optional reset on SENDING rst_at
  task automatic run_frame(input logic [7:0] w, input logic exp_par, input int inj_n,
                           input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] i2,
                           input int rst_at);
    int n_bits;
    logic [7:0] iw;
    n_bits = (rst_at > 0) ? rst_at : 8;
    for (int i = 0; i < n_bits; i++) bit_q.push_back({w[i], (i == 7)});
    if (rst_at == 0) par_q.push_back(exp_par);
    bus.ser_en = 1'b1; bus.mux_sel = 2'b00;
    step();
    for (int s = 1; s <= 8; s++) begin
      bus.mux_sel = 2'b10;
      if ((s % 2 == 0) && (s / 2 <= inj_n)) begin
        iw = (s == 2) ? i0 : ((s == 4) ? i1 : i2);
        bus.DATA_VALID = 1'b1; bus.P_DATA = iw;
        if (tb_held) ovr_q.push_back(cyc + 1);
        else tb_held = 1'b1;
      end
      if (s == rst_at) begin
        check("pending before reset", bus.pending, 1'b1);
        rst = 1'b1;
      end
      step();
      bus.DATA_VALID = 1'b0;
      if (s == rst_at) begin
        rst = 1'b0; bus.ser_en = 1'b0; bus.mux_sel = 2'b00; tb_held = 1'b0;
        check("post-reset ser_data", bus.ser_data, 1'b0);
        check("post-reset ser_done", bus.ser_done, 1'b0);
        check("post-reset pending", bus.pending, 1'b0);
        check("post-reset par_bit", bus.par_bit, 1'b0);
        check("post-reset overrun", bus.overrun, 1'b0);
        return;
      end
    end
    bus.mux_sel = 2'b11;
    step();
    check("pending in stop", bus.pending, tb_held);
    bus.mux_sel = 2'b01;
    step();
    bus.ser_en = 1'b0; bus.mux_sel = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_TYP = 1'b0;
    bus.ser_en = 1'b0; bus.mux_sel = 2'b00;
    step(); step();
    rst = 1'b0;
    check("reset ser_data", bus.ser_data, 1'b0);
    check("reset ser_done", bus.ser_done, 1'b0);
    check("reset pending", bus.pending, 1'b0);
    check("reset par_bit", bus.par_bit, 1'b0);
    check("reset overrun", bus.overrun, 1'b0);

    // T1: A5 even parity -> bits 1,0,1,0,0,1,0,1, parity 0
    bus.PAR_TYP = 1'b0;
    load(8'hA5, 1'b0);
    run_frame(8'hA5, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0);

    // T2: odd parity; mux_sel=10 while idle must not shift
    bus.PAR_TYP = 1'b1;
    load(8'h01, 1'b0);
    for (int k = 0; k < 3; k++) idle_cycle(1'b0, 8'h00, 2'b10);
    run_frame(8'h01, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0);
    load(8'h03, 1'b1);
    run_frame(8'h03, 1'b1, 0, 8'h00, 8'h00, 8'h00, 0);

    // T3: F0 held mid-frame, loads on first idle cycle after STOP
    bus.PAR_TYP = 1'b0;
    load(8'h3C, 1'b0);
    run_frame(8'h3C, 1'b0, 1, 8'hF0, 8'h00, 8'h00, 0);
    check("T3 pending first idle", bus.pending, 1'b1);
    idle_cycle(1'b0, 8'h00, 2'b00);
    check("T3 pending after load", bus.pending, 1'b0);
    check("T3 ser_data after load", bus.ser_data, 1'b0);
    check("T3 par_bit after load", bus.par_bit, 1'b0);
    run_frame(8'hF0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0);

    // T4: three arrivals in one frame -> 11 held, 22 and 33 overrun
    bus.PAR_TYP = 1'b1;
    load(8'hC3, 1'b1);
    run_frame(8'hC3, 1'b1, 3, 8'h11, 8'h22, 8'h33, 0);

    // T6: idle with held word plus new arrival -> 11 loads, 77 held, no overrun
    idle_cycle(1'b1, 8'h77, 2'b00);
    check("T6 pending", bus.pending, 1'b1);
    check("T6 overrun", bus.overrun, 1'b0);
    check("T6 ser_data", bus.ser_data, 1'b1);
    check("T6 par_bit", bus.par_bit, 1'b1);
    run_frame(8'h11, 1'b1, 0, 8'h00, 8'h00, 8'h00, 0);
    idle_cycle(1'b0, 8'h00, 2'b00);
    check("T6 pending drained", bus.pending, 1'b0);
    check("T6 par_bit 77", bus.par_bit, 1'b1);
    run_frame(8'h77, 1'b1, 0, 8'h00, 8'h00, 8'h00, 0);

    // T5: reset on SENDING 4 with a held word, then normal load
    bus.PAR_TYP = 1'b1;
    load(8'hFF, 1'b1);
    run_frame(8'hFF, 1'b1, 1, 8'hAA, 8'h00, 8'h00, 4);
    bus.PAR_TYP = 1'b0;
    load(8'h5A, 1'b0);
    run_frame(8'h5A, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0);

    step(); step();
    check("bit queue drained", bit_q.size(), 0);
    check("parity queue drained", par_q.size(), 0);
    check("overrun queue drained", ovr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
